// File: rtl/otl_pkg.sv
// Shared definitions for the OTL DMA scheduler: FSM states, requester ids and a
// pointer-width helper used by the scheduler and its round-robin picker.
package otl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    typedef enum int {
        REQ_ADC   = 0,
        REQ_DAC   = 1,
        REQ_TRX   = 2,
        REQ_COUNT = 3
    } req_id_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otl_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping to 0.
module otl_rr_pick
    import otl_pkg::*;
#(
    parameter int N    = 3,
    parameter int PTRW = ptr_width(N)
) (
    input  logic [N-1:0]    request,
    input  logic [N-1:0]    mask,
    input  logic [PTRW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic            valid
);

    logic [N-1:0] eligible;
    int           idx;

    assign eligible = request & mask;

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!valid && eligible[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/otl_dma_sched.sv
// DMA command scheduler: round-robin arbitration of ADC/DAC/TRX requests into a
// single otl_axi_dma command channel, with completion/error routing and watchdog.
module otl_dma_sched
    import otl_pkg::*;
#(
    parameter int NREQ  = int'(REQ_COUNT),
    parameter int ADDRW = 32,
    parameter int LENW  = 16,
    parameter int TMOW  = 16
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [NREQ-1:0]       cfg_enable,
    input  logic [TMOW-1:0]       cfg_timeout,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    input  logic [NREQ*LENW-1:0]  req_len,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       req_err,
    output logic                  dma_cmd_valid,
    input  logic                  dma_cmd_ready,
    output logic [ADDRW-1:0]      dma_cmd_addr,
    output logic [LENW-1:0]       dma_cmd_len,
    input  logic                  dma_done,
    input  logic                  dma_err,
    output logic                  dma_abort,
    output logic                  busy,
    output logic [NREQ-1:0]       cur_grant
);

    localparam int PTRW = ptr_width(NREQ);

    sched_state_e    state;
    logic [PTRW-1:0] rr_ptr;
    logic [PTRW-1:0] owner_idx;
    logic [TMOW-1:0] wdog;

    logic [NREQ-1:0]  pick_grant;
    logic             pick_valid;
    logic [PTRW-1:0]  pick_idx;
    logic [ADDRW-1:0] pick_addr;
    logic [LENW-1:0]  pick_len;
    logic [TMOW-1:0]  wdog_inc;
    logic             timeout_hit;

    // A requester whose accept pulse is showing may still hold valid this
    // cycle; masking it prevents a second grant of the same request.
    otl_rr_pick #(.N(NREQ), .PTRW(PTRW)) u_pick (
        .request (req_valid),
        .mask    (cfg_enable & ~req_ready),
        .ptr     (rr_ptr),
        .grant   (pick_grant),
        .valid   (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) pick_idx = PTRW'(i);
        end
    end

    assign pick_addr   = req_addr[int'(pick_idx)*ADDRW +: ADDRW];
    assign pick_len    = req_len[int'(pick_idx)*LENW +: LENW];
    assign wdog_inc    = (wdog == '1) ? wdog : wdog + TMOW'(1);
    assign timeout_hit = (cfg_timeout != '0) && (wdog_inc >= cfg_timeout);
    assign busy        = (state != ST_IDLE);

    function automatic logic [PTRW-1:0] inc_ptr(input logic [PTRW-1:0] p);
        return (int'(p) == NREQ - 1) ? PTRW'(REQ_ADC) : p + PTRW'(1);
    endfunction

    // NOTE: all state here updates with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= ST_IDLE;
            rr_ptr        <= PTRW'(REQ_ADC);
            owner_idx     <= '0;
            wdog          <= '0;
            req_ready     <= '0;
            req_done      <= '0;
            req_err       <= '0;
            dma_cmd_valid <= 1'b0;
            dma_cmd_addr  <= '0;
            dma_cmd_len   <= '0;
            dma_abort     <= 1'b0;
            cur_grant     <= '0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            dma_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        req_ready <= pick_grant;
                        if (pick_len == '0) begin
                            req_done <= pick_grant;
                            rr_ptr   <= inc_ptr(pick_idx);
                        end else begin
                            dma_cmd_addr  <= pick_addr;
                            dma_cmd_len   <= pick_len;
                            dma_cmd_valid <= 1'b1;
                            cur_grant     <= pick_grant;
                            owner_idx     <= pick_idx;
                            state         <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (dma_cmd_ready) begin
                        dma_cmd_valid <= 1'b0;
                        wdog          <= '0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wdog <= wdog_inc;
                    if (dma_err || dma_done || timeout_hit) begin
                        // Error outranks completion; a completion outranks the watchdog.
                        if (dma_err) begin
                            req_err <= cur_grant;
                        end else if (dma_done) begin
                            req_done <= cur_grant;
                        end else begin
                            req_err   <= cur_grant;
                            dma_abort <= 1'b1;
                        end
                        cur_grant <= '0;
                        rr_ptr    <= inc_ptr(owner_idx);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otl_dma_sched.sv
// Directed bench for otl_dma_sched with a transaction-level reference model
// compared against the DUT every cycle, plus literal scenario expectations.
module tb_otl_dma_sched;

    localparam int NREQ  = 3;
    localparam int ADDRW = 32;
    localparam int LENW  = 16;
    localparam int TMOW  = 16;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       cfg_enable;
    logic [TMOW-1:0]       cfg_timeout;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*LENW-1:0]  req_len;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_done;
    logic [NREQ-1:0]       req_err;
    logic                  dma_cmd_valid;
    logic                  dma_cmd_ready;
    logic [ADDRW-1:0]      dma_cmd_addr;
    logic [LENW-1:0]       dma_cmd_len;
    logic                  dma_done;
    logic                  dma_err;
    logic                  dma_abort;
    logic                  busy;
    logic [NREQ-1:0]       cur_grant;

    otl_dma_sched #(.NREQ(NREQ), .ADDRW(ADDRW), .LENW(LENW), .TMOW(TMOW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cfg_enable    (cfg_enable),
        .cfg_timeout   (cfg_timeout),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .req_done      (req_done),
        .req_err       (req_err),
        .dma_cmd_valid (dma_cmd_valid),
        .dma_cmd_ready (dma_cmd_ready),
        .dma_cmd_addr  (dma_cmd_addr),
        .dma_cmd_len   (dma_cmd_len),
        .dma_done      (dma_done),
        .dma_err       (dma_err),
        .dma_abort     (dma_abort),
        .busy          (busy),
        .cur_grant     (cur_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    int grant_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), command outstanding flag, cycles waited.
    int               m_owner  = -1;
    bit               m_cmd    = 1'b0;
    int               m_ptr    = 0;
    int               m_waited = 0;
    logic [NREQ-1:0]  e_ready  = '0;
    logic [NREQ-1:0]  e_done   = '0;
    logic [NREQ-1:0]  e_err    = '0;
    logic             e_abort  = 1'b0;
    logic [ADDRW-1:0] e_addr   = '0;
    logic [LENW-1:0]  e_len    = '0;

    task automatic model_reset();
        m_owner = -1; m_cmd = 1'b0; m_ptr = 0; m_waited = 0;
        e_ready = '0; e_done = '0; e_err = '0; e_abort = 1'b0;
        e_addr  = '0; e_len  = '0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] shown;
        int found;
        int i;
        bit finished;
        shown = e_ready;
        found = -1;
        finished = 1'b0;
        e_ready = '0; e_done = '0; e_err = '0; e_abort = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (found < 0 && req_valid[i] && cfg_enable[i] && !shown[i]) found = i;
            end
            if (found >= 0) begin
                e_ready[found] = 1'b1;
                if (req_len[found*LENW +: LENW] == '0) begin
                    e_done[found] = 1'b1;
                    m_ptr = (found + 1) % NREQ;
                end else begin
                    m_owner = found;
                    m_cmd   = 1'b1;
                    e_addr  = req_addr[found*ADDRW +: ADDRW];
                    e_len   = req_len[found*LENW +: LENW];
                end
            end
        end else if (m_cmd) begin
            if (dma_cmd_ready) begin
                m_cmd = 1'b0;
                m_waited = 0;
            end
        end else begin
            if (m_waited < (1 << TMOW) - 1) m_waited++;
            if (dma_err) begin
                e_err[m_owner] = 1'b1; finished = 1'b1;
            end else if (dma_done) begin
                e_done[m_owner] = 1'b1; finished = 1'b1;
            end else if (cfg_timeout != '0 && m_waited >= int'(cfg_timeout)) begin
                e_err[m_owner] = 1'b1; e_abort = 1'b1; finished = 1'b1;
            end
            if (finished) begin
                m_ptr = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: every cycle, on the falling edge.
    initial begin
        logic [NREQ-1:0] g;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                g = '0;
                if (m_owner >= 0) g[m_owner] = 1'b1;
                check("req_ready", req_ready, e_ready);
                check("req_done", req_done, e_done);
                check("req_err", req_err, e_err);
                check("dma_abort", dma_abort, e_abort);
                check("dma_cmd_valid", dma_cmd_valid, (m_owner >= 0) && m_cmd);
                check("dma_cmd_addr", dma_cmd_addr, e_addr);
                check("dma_cmd_len", dma_cmd_len, e_len);
                check("busy", busy, m_owner >= 0);
                check("cur_grant", cur_grant, g);
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) grant_log.push_back(j);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    // One clock step; a requester drops valid after the cycle its ready showed.
    task automatic tick();
        logic [NREQ-1:0] seen;
        seen = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~seen;
    endtask

    task automatic set_req(input int i, input logic [ADDRW-1:0] a, input logic [LENW-1:0] l);
        req_addr[i*ADDRW +: ADDRW] = a;
        req_len[i*LENW +: LENW]    = l;
    endtask

    task automatic handshake();
        int n;
        n = 0;
        while (!dma_cmd_valid && n < 50) begin tick(); n++; end
        check("cmd_wait_bound", n < 50, 1'b1);
        dma_cmd_ready = 1'b1;
        tick();
        dma_cmd_ready = 1'b0;
    endtask

    task automatic serve(input int lat);
        handshake();
        repeat (lat) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cfg_enable = '0; cfg_timeout = '0; req_valid = '0;
        req_addr = '0; req_len = '0; dma_cmd_ready = 1'b0; dma_done = 1'b0; dma_err = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_grant", cur_grant, 3'b000);
        check("rst_cmd_addr", dma_cmd_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        cfg_enable = 3'b111;

        // ADC single transfer, then pointer moves to DAC.
        set_req(0, 32'h1000, 16'd64);
        req_valid = 3'b001;
        tick();
        check("s1_ready", req_ready, 3'b001);
        check("s1_cmd_valid", dma_cmd_valid, 1'b1);
        check("s1_cmd_addr", dma_cmd_addr, 32'h1000);
        check("s1_cmd_len", dma_cmd_len, 16'd64);
        dma_cmd_ready = 1'b1; tick(); dma_cmd_ready = 1'b0;
        check("s1_cmd_dropped", dma_cmd_valid, 1'b0);
        repeat (3) tick();
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        check("s1_done", req_done, 3'b001);
        check("s1_idle", busy, 1'b0);
        set_req(0, 32'h1100, 16'd4);
        set_req(1, 32'h2000, 16'd8);
        grant_log.delete();
        req_valid = 3'b011;
        serve(2);
        serve(1);
        check("s1_ptr_first", grant_log.size() > 0 ? grant_log[0] : -1, 1);
        check("s1_ptr_second", grant_log.size() > 1 ? grant_log[1] : -1, 0);

        // All three requesting: order from a fresh pointer is 0,1,2,0.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_req(0, 32'h1000, 16'd1);
        set_req(1, 32'h2000, 16'd2);
        set_req(2, 32'h3000, 16'd3);
        grant_log.delete();
        req_valid = 3'b111;
        serve(1);
        req_valid[0] = 1'b1;
        serve(1);
        serve(1);
        serve(1);
        check("s2_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            int exp_order[4];
            exp_order = '{0, 1, 2, 0};
            check("s2_order", grant_log.size() > k ? grant_log[k] : -1, exp_order[k]);
        end

        // Watchdog of 10 cycles, then of 1 cycle.
        cfg_timeout = 16'd10;
        set_req(2, 32'h3300, 16'd16);
        req_valid = 3'b100;
        handshake();
        n = 0;
        while (!dma_abort && n < 40) begin tick(); n++; end
        check("s3_abort_latency", n, 10);
        check("s3_err", req_err, 3'b100);
        check("s3_no_done", req_done, 3'b000);
        cfg_timeout = 16'd1;
        set_req(0, 32'h1400, 16'd2);
        req_valid = 3'b001;
        handshake();
        n = 0;
        while (!dma_abort && n < 40) begin tick(); n++; end
        check("s3_abort_latency_1", n, 1);
        cfg_timeout = 16'd0;

        // Responses outside WAIT ignored; coincident done+err reports error.
        set_req(1, 32'h2200, 16'd5);
        req_valid = 3'b010;
        tick();
        dma_done = 1'b1; dma_err = 1'b1; tick(); dma_done = 1'b0; dma_err = 1'b0;
        check("s4_issue_ignores_done", req_done | req_err, 3'b000);
        check("s4_issue_holds", dma_cmd_valid, 1'b1);
        handshake();
        tick();
        dma_done = 1'b1; dma_err = 1'b1; tick(); dma_done = 1'b0; dma_err = 1'b0;
        check("s4_err_wins", req_err, 3'b010);
        check("s4_no_done", req_done, 3'b000);

        // Zero-length request: accepted and completed together, no command.
        set_req(0, 32'h1500, 16'd0);
        req_valid = 3'b001;
        tick();
        check("s5_ready", req_ready, 3'b001);
        check("s5_done", req_done, 3'b001);
        check("s5_no_cmd", dma_cmd_valid, 1'b0);
        tick();
        check("s5_no_regrant", req_ready, 3'b000);
        check("s5_still_idle", busy, 1'b0);

        // Disabled DAC is skipped; dropping the owner's enable does not abort it.
        cfg_enable = 3'b101;
        set_req(0, 32'h1600, 16'd8);
        set_req(1, 32'h2600, 16'd8);
        req_valid = 3'b011;
        tick();
        check("s6_grant_skips_disabled", cur_grant, 3'b001);
        cfg_enable = 3'b100;
        serve(2);
        check("s6_done_after_disable", req_done, 3'b001);
        repeat (3) tick();
        check("s6_dac_masked", busy, 1'b0);

        // Reset in WAIT clears everything at once; ADC wins first afterwards.
        cfg_enable = 3'b111;
        tick();
        check("s7_grant_dac", cur_grant, 3'b010);
        handshake();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("s7_rst_busy", busy, 1'b0);
        check("s7_rst_grant", cur_grant, 3'b000);
        check("s7_rst_addr", dma_cmd_addr, 32'h0);
        check("s7_rst_len", dma_cmd_len, 16'h0);
        check("s7_rst_pulses", {req_done, req_err, dma_abort, dma_cmd_valid}, 8'h00);
        tick();
        rst_n = 1'b1;
        set_req(0, 32'h1700, 16'd3);
        set_req(1, 32'h2700, 16'd3);
        set_req(2, 32'h3700, 16'd3);
        req_valid = 3'b111;
        tick();
        check("s7_first_grant", req_ready, 3'b001);
        serve(1);
        serve(1);
        serve(1);
        repeat (2) tick();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
